// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file write arbiter slice.
package regfile_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // One register-file write request; shared by the WB, FIFO and output paths.
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    typedef enum logic {
        ARB_RUN,
        ARB_HOLD
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_WB,
        GRANT_FIFO
    } grant_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of pipeline, long-latency, decode and register-file signals seen by the arbiter.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                wb_valid;
    reg_addr_t           wb_reg;
    reg_data_t           wb_data;
    logic                lu_valid;
    logic                lu_ready;
    reg_addr_t           lu_reg;
    reg_data_t           lu_data;
    logic                lu_issue;
    reg_addr_t           lu_issue_reg;
    reg_addr_t           dec_src1;
    reg_addr_t           dec_src2;
    reg_addr_t           dec_dst;
    logic                stall;
    logic                pipe_hold;
    logic                wr_enable;
    reg_addr_t           wr_reg;
    reg_data_t           wr_data;
    logic [NUM_REGS-1:0] pending;

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  lu_valid, lu_reg, lu_data, lu_issue, lu_issue_reg,
        input  dec_src1, dec_src2, dec_dst,
        output lu_ready, stall, pipe_hold,
        output wr_enable, wr_reg, wr_data, pending
    );

    modport master (
        output wb_valid, wb_reg, wb_data,
        output lu_valid, lu_reg, lu_data, lu_issue, lu_issue_reg,
        output dec_src1, dec_src2, dec_dst,
        input  lu_ready, stall, pipe_hold,
        input  wr_enable, wr_reg, wr_data, pending
    );

endinterface

// File: rtl/regfile_result_fifo.sv
// Synchronous buffer for long-latency results; push and pop may occur in the same cycle.
module regfile_result_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wr_req_t pushReq,
    input  logic    pop,
    output wr_req_t headReq,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    wr_req_t        mem [DEPTH];
    logic [PTR_W:0] wrPtr;
    logic [PTR_W:0] rdPtr;
    logic           doPush;
    logic           doPop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign headReq = mem[rdPtr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[PTR_W-1:0]] <= pushReq;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback and buffered long-latency results.
// Optional starvation guard (counter + pipe_hold) is enabled by `define REGFILE_ARB_STARVE_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
`ifdef REGFILE_ARB_STARVE_EN
    ,
    parameter int unsigned STARVE_LIMIT = 8
`endif
) (
    input logic                    clk,
    input logic                    rst_n,
    regfile_write_arbiter_if.slave bus
);

    arb_state_e          state;
    arb_state_e          stateNext;
    grant_e              grant;
    wr_req_t             wbReq;
    wr_req_t             luReq;
    wr_req_t             fifoHead;
    wr_req_t             winner;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                wrEnable;
    reg_addr_t           wrAddr;
    reg_data_t           wrData;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pendingNext;

`ifdef REGFILE_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starveCnt;
    logic [CNT_W-1:0] starveCntNext;
`endif

    assign wbReq    = '{valid: bus.wb_valid, addr: bus.wb_reg, data: bus.wb_data};
    assign luReq    = '{valid: 1'b1, addr: bus.lu_reg, data: bus.lu_data};
    assign fifoPush = bus.lu_valid && !fifoFull;

    regfile_result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (fifoPush),
        .pushReq(luReq),
        .pop    (fifoPop),
        .headReq(fifoHead),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant       = GRANT_IDLE;
        winner      = '0;
        stateNext   = ARB_RUN;
        pendingNext = pending;

        if (bus.wb_valid && state != ARB_HOLD) begin
            grant  = GRANT_WB;
            winner = wbReq;
        end else if (!fifoEmpty) begin
            grant  = GRANT_FIFO;
            winner = fifoHead;
        end
        fifoPop = (grant == GRANT_FIFO);

        // Clear first so a same-edge issue to the popped index keeps it pending.
        if (fifoPop) pendingNext[fifoHead.addr] = 1'b0;
        if (bus.lu_issue && bus.lu_issue_reg != '0) pendingNext[bus.lu_issue_reg] = 1'b1;

`ifdef REGFILE_ARB_STARVE_EN
        starveCntNext = (fifoEmpty || fifoPop) ? '0 : starveCnt + 1'b1;
        if (starveCntNext >= STARVE_MAX) stateNext = ARB_HOLD;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_RUN;
            wrEnable <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
            pending  <= '0;
        end else begin
            state    <= stateNext;
            wrEnable <= winner.valid && (winner.addr != '0);
            if (winner.valid) begin
                wrAddr <= winner.addr;
                wrData <= winner.data;
            end
            pending  <= pendingNext;
        end
    end

`ifdef REGFILE_ARB_STARVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starveCnt <= '0;
        else        starveCnt <= starveCntNext;
    end

    wbDuringHold: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.wb_valid && bus.pipe_hold));
`endif

    assign bus.lu_ready  = !fifoFull;
    assign bus.pipe_hold = (state == ARB_HOLD);
    assign bus.wr_enable = wrEnable;
    assign bus.wr_reg    = wrAddr;
    assign bus.wr_data   = wrData;
    assign bus.pending   = pending;
    assign bus.stall     = pending[bus.dec_src1] | pending[bus.dec_src2] | pending[bus.dec_dst];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int          STARVE = 8;

    typedef struct {
        reg_addr_t addr;
        reg_data_t data;
    } entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model state
    entry_t              mq[$];
    logic [NUM_REGS-1:0] expPending;
    bit                  expWrEn;
    reg_addr_t           expWrReg;
    reg_data_t           expWrData;
    int                  starveCnt;
    bit                  expHold;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        expPending = '0;
        expWrEn    = 1'b0;
        expWrReg   = '0;
        expWrData  = '0;
        starveCnt  = 0;
        expHold    = 1'b0;
    endtask

    // One clock edge worth of arbiter behaviour, from the rules rather than the RTL structure.
    task automatic modelStep();
        bit        granted;
        bit        popped;
        bit        wasNonEmpty;
        bit        canPush;
        reg_addr_t gReg;
        reg_data_t gData;
        entry_t    e;
        granted     = 1'b0;
        popped      = 1'b0;
        gReg        = '0;
        gData       = '0;
        wasNonEmpty = (mq.size() != 0);
        canPush     = (mq.size() < DEPTH);
        if (bus.wb_valid && !expHold) begin
            granted = 1'b1;
            gReg    = bus.wb_reg;
            gData   = bus.wb_data;
        end else if (mq.size() > 0) begin
            e       = mq.pop_front();
            granted = 1'b1;
            popped  = 1'b1;
            gReg    = e.addr;
            gData   = e.data;
            expPending[e.addr] = 1'b0;
        end
        if (bus.lu_issue && bus.lu_issue_reg != 0) expPending[bus.lu_issue_reg] = 1'b1;
        if (bus.lu_valid && canPush) begin
            e.addr = bus.lu_reg;
            e.data = bus.lu_data;
            mq.push_back(e);
        end
        expWrEn = granted && (gReg != 0);
        if (granted) begin
            expWrReg  = gReg;
            expWrData = gData;
        end
`ifdef REGFILE_ARB_STARVE_EN
        if (wasNonEmpty && !popped) starveCnt++;
        else                        starveCnt = 0;
        expHold = (starveCnt >= STARVE);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
    endtask

    task automatic setIdle();
        bus.wb_valid     = 1'b0;
        bus.wb_reg       = '0;
        bus.wb_data      = '0;
        bus.lu_valid     = 1'b0;
        bus.lu_reg       = '0;
        bus.lu_data      = '0;
        bus.lu_issue     = 1'b0;
        bus.lu_issue_reg = '0;
        bus.dec_src1     = '0;
        bus.dec_src2     = '0;
        bus.dec_dst      = '0;
    endtask

    // Continuous comparison of every observable output against the model.
    always @(negedge clk) begin
        if (rst_n && checkEn) begin
            check("wr_enable", bus.wr_enable, expWrEn);
            if (expWrEn) begin
                check("wr_reg", bus.wr_reg, expWrReg);
                check("wr_data", bus.wr_data, expWrData);
            end
            check("lu_ready", bus.lu_ready, mq.size() < DEPTH);
            check("pending", bus.pending, expPending);
            check("stall", bus.stall,
                  expPending[bus.dec_src1] | expPending[bus.dec_src2] | expPending[bus.dec_dst]);
            check("pipe_hold", bus.pipe_hold, expHold);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int wbPct;
        setIdle();
        modelReset();
        checkEn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset wr_enable", bus.wr_enable, 0);
        check("reset lu_ready", bus.lu_ready, 1);
        check("reset pending", bus.pending, 0);
        check("reset pipe_hold", bus.pipe_hold, 0);

        // Writeback goes straight through with one cycle of latency
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 5;
        bus.wb_data  = 32'hA5;
        cycle();
        bus.wb_valid = 1'b0;
        check("wb wr_enable", bus.wr_enable, 1);
        check("wb wr_reg", bus.wr_reg, 5);
        check("wb wr_data", bus.wr_data, 32'hA5);

        // Scoreboard stall and release on the result write
        bus.lu_issue     = 1'b1;
        bus.lu_issue_reg = 9;
        bus.dec_src1     = 9;
        cycle();
        bus.lu_issue = 1'b0;
        check("issue stall", bus.stall, 1);
        check("issue pending9", bus.pending[9], 1);
        bus.lu_valid = 1'b1;
        bus.lu_reg   = 9;
        bus.lu_data  = 32'h1234;
        cycle();
        bus.lu_valid = 1'b0;
        check("push no write", bus.wr_enable, 0);
        cycle();
        check("lu write en", bus.wr_enable, 1);
        check("lu write reg", bus.wr_reg, 9);
        check("lu write data", bus.wr_data, 32'h1234);
        check("lu pending9 clr", bus.pending[9], 0);
        check("lu stall clr", bus.stall, 0);
        bus.dec_src1 = 0;

        // Writeback hogs the port while the FIFO fills, then FIFO drains in order
        bus.wb_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wb_reg   = reg_addr_t'(20 + i);
            bus.wb_data  = 32'h100 + i;
            bus.lu_valid = (i < 4);
            bus.lu_reg   = reg_addr_t'(10 + i);
            bus.lu_data  = 32'h200 + i;
            cycle();
            check("hog wb reg", bus.wr_reg, 20 + i);
            if (i == 3) check("fifo full ready", bus.lu_ready, 0);
        end
        bus.wb_valid = 1'b0;
        bus.lu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("drain en", bus.wr_enable, 1);
            check("drain reg", bus.wr_reg, 10 + i);
            check("drain data", bus.wr_data, 32'h200 + i);
        end
        cycle();
        check("drain done", bus.wr_enable, 0);

`ifdef REGFILE_ARB_STARVE_EN
        // Starvation guard forces the FIFO head through
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 1;
        bus.lu_valid = 1'b1;
        bus.lu_reg   = 17;
        bus.lu_data  = 32'hBEEF;
        cycle();
        bus.lu_valid = 1'b0;
        waited = 0;
        while (!bus.pipe_hold && waited < 20) begin
            cycle();
            waited++;
        end
        check("hold latency", waited, 8);
        bus.wb_valid = 1'b0;
        cycle();
        check("forced en", bus.wr_enable, 1);
        check("forced reg", bus.wr_reg, 17);
        check("forced data", bus.wr_data, 32'hBEEF);
        check("hold release", bus.pipe_hold, 0);
        bus.wb_valid = 1'b1;
        repeat (3) cycle();
        check("hold stays low", bus.pipe_hold, 0);
        bus.wb_valid = 1'b0;
`endif

        // Register 0 results are popped but never written
        bus.lu_valid = 1'b1;
        bus.lu_reg   = 0;
        bus.lu_data  = 32'hDEAD;
        cycle();
        bus.lu_reg  = 7;
        bus.lu_data = 32'h77;
        cycle();
        bus.lu_valid = 1'b0;
        check("reg0 no write", bus.wr_enable, 0);
        cycle();
        check("after reg0 en", bus.wr_enable, 1);
        check("after reg0 reg", bus.wr_reg, 7);

        // Issue and pop of the same register on one edge: the new issue wins
        bus.lu_issue     = 1'b1;
        bus.lu_issue_reg = 3;
        cycle();
        bus.lu_issue = 1'b0;
        bus.lu_valid = 1'b1;
        bus.lu_reg   = 3;
        bus.lu_data  = 32'h33;
        cycle();
        bus.lu_valid = 1'b0;
        bus.lu_issue = 1'b1;
        cycle();
        bus.lu_issue = 1'b0;
        check("set-wins write", bus.wr_reg, 3);
        check("set-wins pending3", bus.pending[3], 1);

        // Asynchronous reset in the middle of a drain
        bus.wb_valid = 1'b1;
        bus.wb_reg   = 2;
        for (int i = 0; i < 3; i++) begin
            bus.lu_valid     = 1'b1;
            bus.lu_reg       = reg_addr_t'(24 + i);
            bus.lu_data      = 32'h300 + i;
            bus.lu_issue     = 1'b1;
            bus.lu_issue_reg = reg_addr_t'(24 + i);
            cycle();
        end
        setIdle();
        cycle();
        check("pre-reset write", bus.wr_enable, 1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        check("async wr_enable", bus.wr_enable, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset pending", bus.pending, 0);
        check("post-reset ready", bus.lu_ready, 1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("no stale write", bus.wr_enable, 0);
        end

        // Randomized traffic, light then heavy writeback pressure
        for (int n = 0; n < 3000; n++) begin
            wbPct = (n < 1500) ? 45 : 90;
            bus.wb_valid     = expHold ? 1'b0 : ($urandom_range(0, 99) < wbPct);
            bus.wb_reg       = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            bus.wb_data      = $urandom;
            bus.lu_valid     = ($urandom_range(0, 99) < 55);
            bus.lu_reg       = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            bus.lu_data      = $urandom;
            bus.lu_issue     = ($urandom_range(0, 99) < 30);
            bus.lu_issue_reg = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            bus.dec_src1     = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            bus.dec_src2     = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            bus.dec_dst      = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            cycle();
        end

        setIdle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
